// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS control path:
// FSM state encoding, opcode/funct fields and ALU operation codes.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;

  localparam logic [3:0] ALU_NOTA = 4'b0000;
  localparam logic [3:0] ALU_NOTB = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode: maps ALUOp (and Funct for R-type) to ALUControl.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_control
);

  // ALUOp/Funct to ALU operation select
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FUNCT_ADD: o_alu_control = ALU_ADD;
          FUNCT_SUB: o_alu_control = ALU_SUB;
          FUNCT_AND: o_alu_control = ALU_AND;
          FUNCT_OR:  o_alu_control = ALU_OR;
          FUNCT_XOR: o_alu_control = ALU_XOR;
          default:   o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: Moore control outputs decoded from State,
// with PCEn combining the unconditional PC write and the taken-branch term.
module mips_mc_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [3:0] State
);

  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_illegal;
  logic [1:0] w_alu_op;
  logic [3:0] w_alu_ctrl;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next    = S_FETCH;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    w_alu_op  = ALUOP_ADD;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        IRWrite   = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        w_alu_op = ALUOP_SUB;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: begin
        w_illegal = 1'b1;
        w_next    = S_FETCH;
      end
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct       (Funct),
    .o_alu_control (w_alu_ctrl)
  );

  // An unused encoding must present an all-zero ALUControl as well
  assign ALUControl = w_illegal ? 4'b0000 : w_alu_ctrl;
  assign PCEn       = w_pcwrite | (w_branch & Zero);
  assign State      = r_state;

endmodule
